dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 32 +++
 rtl/dmem_array.sv | 35 +++
 rtl/dmem_responder.sv | 117 +++++++++++
 tb/tb_dmem_responder.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states
// and the byte-lane helpers used by the responder.
package dmem_responder_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic len_legal(input logic [2:0] len);
        return (len == LEN_B) || (len == LEN_H) || (len == LEN_W);
    endfunction

    // Lane mask for an access of the given size starting at byte offset off.
    function automatic logic [3:0] byte_en(input logic [2:0] len, input logic [1:0] off);
        logic [3:0] base;
        case (len)
            LEN_B:   base = 4'b0001;
            LEN_H:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with per-byte write enables and a registered,
// read-enabled output that holds its value between reads.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // NOTE: neither the storage nor the read register is reset, so the array maps onto RAM macros.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    r_mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (re_i) begin
            r_rdata <= r_mem[addr_i];
        end
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder for the memory stage: one outstanding request, fixed
// access latency, byte-lane stores and right-aligned load data.
module dmem_responder #(
    parameter int XLEN        = dmem_responder_pkg::XLEN,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic [2:0]      req_len_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o
);
    import dmem_responder_pkg::*;

    localparam int              AW         = $clog2(DEPTH_WORDS);
    localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(4 * DEPTH_WORDS);
    localparam logic [3:0]      LAT_M1     = 4'(LATENCY - 1);

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic          r_err;
    logic [1:0]    r_off;
    logic [AW-1:0] r_word;

    logic          w_accept;
    logic          w_err;
    logic          w_misaligned;
    logic          w_wait_done;
    logic          w_arr_we;
    logic          w_arr_re;
    logic [AW-1:0] w_arr_addr;
    logic [31:0]   w_wdata_sh;
    logic [31:0]   w_arr_rdata;

    assign req_ready_o = (r_state == ST_IDLE);
    assign w_accept    = req_valid_i & req_ready_o;

    assign w_misaligned = ((req_len_i == LEN_H) && req_addr_i[0])
                       || ((req_len_i == LEN_W) && (req_addr_i[1:0] != 2'b00));
    assign w_err        = !len_legal(req_len_i) || w_misaligned || (req_addr_i >= ADDR_LIMIT);

    assign w_wait_done = (r_state == ST_WAIT) && (r_cnt == 4'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next takes a default before the case so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_next = ST_WAIT;
            ST_WAIT: if (w_wait_done) w_next = ST_RESP;
            ST_RESP: if (rsp_ready_i) w_next = ST_IDLE;
            default:                  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= LAT_M1;
        end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Request capture needs no reset: every output is qualified by r_state.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_we   <= req_we_i;
            r_err  <= w_err;
            r_off  <= req_addr_i[1:0];
            r_word <= req_addr_i[AW+1:2];
        end
    end

    // Stores use the live request address at acceptance; loads use the captured one.
    assign w_arr_addr = req_ready_o ? req_addr_i[AW+1:2] : r_word;
    assign w_arr_we   = w_accept & req_we_i & ~w_err;
    assign w_arr_re   = w_wait_done & ~r_we & ~r_err;
    assign w_wdata_sh = req_wdata_i[31:0] << {req_addr_i[1:0], 3'b000};

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (w_arr_we),
        .be_i    (byte_en(req_len_i, req_addr_i[1:0])),
        .re_i    (w_arr_re),
        .addr_i  (w_arr_addr),
        .wdata_i (w_wdata_sh),
        .rdata_o (w_arr_rdata)
    );

    assign rsp_valid_o = (r_state == ST_RESP);
    assign rsp_err_o   = (r_state == ST_RESP) && r_err;
    assign rsp_rdata_o = ((r_state == ST_RESP) && !r_we && !r_err)
                       ? XLEN'(w_arr_rdata >> {r_off, 3'b000}) : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-level memory model predicts each
// response when the request is driven; responses are popped and compared.
module tb_dmem_responder;

    localparam int LATENCY     = 2;
    localparam int DEPTH_WORDS = 1024;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [2:0]  req_len_i = 3'd4;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    dmem_responder #(
        .XLEN        (32),
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_len_i   (req_len_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem_m [int unsigned];
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic logic model_err(input logic [31:0] a, input logic [2:0] len);
        logic bad_len;
        bad_len = !((len == 3'd1) || (len == 3'd2) || (len == 3'd4));
        return bad_len || ((len == 3'd2) && a[0]) || ((len == 3'd4) && (a[1:0] != 2'b00))
            || (a >= 32'(4 * DEPTH_WORDS));
    endfunction

    task automatic model_apply(input logic we, input logic [31:0] a, input logic [31:0] wd,
                               input logic [2:0] len, output exp_t e);
        e.rdata = '0;
        e.err   = model_err(a, len);
        if (!e.err) begin
            if (we) begin
                for (int i = 0; i < int'(len); i++) mem_m[a + 32'(i)] = wd[8*i +: 8];
            end else begin
                for (int j = 0; j < 4 - int'(a[1:0]); j++)
                    e.rdata[8*j +: 8] = mem_m.exists(a + 32'(j)) ? mem_m[a + 32'(j)] : 8'h00;
            end
        end
    endtask

    // Drives one request while IDLE and returns #1 after its acceptance edge.
    task automatic start_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [2:0] len, input bit push);
        exp_t e;
        @(negedge clk_i);
        n_tests++;
        if (req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL start_req_ready: req_ready_o=%b required 1 (addr=%h)", req_ready_o, a);
        end
        req_we_i    = we;
        req_addr_i  = a;
        req_wdata_i = wd;
        req_len_i   = len;
        req_valid_i = 1'b1;
        model_apply(we, a, wd, len, e);
        if (push) exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_we_i    = 1'($urandom);
        req_addr_i  = $urandom;
        req_wdata_i = $urandom;
        req_len_i   = 3'($urandom);
    endtask

    // Waits (bounded) for the response, compares it with the scoreboard, then consumes it.
    task automatic collect(input string name, input bit chk_lat);
        exp_t e;
        int   k = 0;
        while (rsp_valid_o !== 1'b1 && k < 20) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        if (chk_lat) begin
            n_tests++;
            if (k != LATENCY) begin
                n_fail++;
                $display("FAIL %s_latency: got %0d cycles required %0d", name, k, LATENCY);
            end
        end
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_scoreboard: response with no expected entry", name);
        end else begin
            e = exp_q.pop_front();
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err) begin
                n_fail++;
                $display("FAIL %s: valid=%b rdata=%h err=%b required valid=1 rdata=%h err=%b",
                         name, rsp_valid_o, rsp_rdata_o, rsp_err_o, e.rdata, e.err);
            end
        end
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
        n_tests++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_consume: rsp_valid_o=%b req_ready_o=%b required 0/1",
                     name, rsp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        n_tests++;
        if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b rdata=%h err=%b required 0/0/0",
                     rsp_valid_o, rsp_rdata_o, rsp_err_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        n_tests++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: req_ready_o=%b rsp_valid_o=%b required 1/0",
                     req_ready_o, rsp_valid_o);
        end
    endtask

    task automatic test_store_load();
        start_req(1'b1, 32'h10, 32'hDEADBEEF, 3'd4, 1'b1);
        collect("store_word", 1'b1);
        start_req(1'b0, 32'h10, 32'h0, 3'd4, 1'b1);
        collect("load_word", 1'b1);
    endtask

    task automatic test_byte_merge();
        start_req(1'b1, 32'h12, 32'hFFFFFF55, 3'd1, 1'b1);
        collect("store_byte", 1'b1);
        start_req(1'b0, 32'h10, 32'h0, 3'd4, 1'b1);
        collect("load_merged", 1'b1);
        start_req(1'b0, 32'h12, 32'h0, 3'd2, 1'b1);
        collect("load_half_hi", 1'b1);
        start_req(1'b0, 32'h13, 32'h0, 3'd1, 1'b1);
        collect("load_byte3", 1'b1);
    endtask

    task automatic test_errors();
        start_req(1'b0, 32'h11, 32'h0, 3'd2, 1'b1);
        collect("err_half_misaligned", 1'b1);
        start_req(1'b1, 32'h20, 32'h11223344, 3'd4, 1'b1);
        collect("store_0x20", 1'b1);
        start_req(1'b1, 32'h22, 32'hCAFEF00D, 3'd4, 1'b1);
        collect("err_word_misaligned", 1'b1);
        start_req(1'b0, 32'h20, 32'h0, 3'd4, 1'b1);
        collect("load_0x20_unchanged", 1'b1);
        start_req(1'b0, 32'h10, 32'h0, 3'd3, 1'b1);
        collect("err_len3", 1'b1);
        start_req(1'b1, 32'h10, 32'h0, 3'd0, 1'b1);
        collect("err_len0_store", 1'b1);
    endtask

    task automatic test_bounds();
        start_req(1'b0, 32'(4 * DEPTH_WORDS), 32'h0, 3'd4, 1'b1);
        collect("err_past_end", 1'b1);
        start_req(1'b0, 32'hFFFFFFFC, 32'h0, 3'd4, 1'b1);
        collect("err_far_addr", 1'b1);
        start_req(1'b1, 32'(4 * DEPTH_WORDS - 4), 32'h0BADF00D, 3'd4, 1'b1);
        collect("store_last_word", 1'b1);
        start_req(1'b0, 32'(4 * DEPTH_WORDS - 4), 32'h0, 3'd4, 1'b1);
        collect("load_last_word", 1'b1);
        start_req(1'b0, 32'(4 * DEPTH_WORDS - 1), 32'h0, 3'd1, 1'b1);
        collect("load_last_byte", 1'b1);
    endtask

    task automatic test_backpressure();
        logic [31:0] s_rdata;
        logic        s_err;
        int          bad = 0;
        start_req(1'b0, 32'h10, 32'h0, 3'd4, 1'b1);
        repeat (LATENCY) begin
            @(posedge clk_i);
            #1;
        end
        s_rdata = rsp_rdata_o;
        s_err   = rsp_err_o;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            req_valid_i = 1'b1;
            req_we_i    = 1'b1;
            req_addr_i  = 32'h10;
            req_wdata_i = 32'h0;
            req_len_i   = 3'd4;
            @(posedge clk_i);
            #1;
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== s_rdata || rsp_err_o !== s_err
                || req_ready_o !== 1'b0) bad++;
        end
        req_valid_i = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: %0d unstable cycles required 0", bad);
        end
        collect("backpressure_load", 1'b0);
        start_req(1'b0, 32'h10, 32'h0, 3'd4, 1'b1);
        collect("backpressure_no_store", 1'b1);
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        start_req(1'b1, 32'h30, 32'h89ABCDEF, 3'd4, 1'b0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        n_tests++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: rsp_valid_o=%b req_ready_o=%b required 0/1",
                     rsp_valid_o, req_ready_o);
        end
        repeat (LATENCY + 3) begin
            @(posedge clk_i);
            #1;
            if (rsp_valid_o !== 1'b0) stale++;
        end
        n_tests++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL reset_mid_stale: %0d cycles with rsp_valid_o=1 required 0", stale);
        end
        start_req(1'b0, 32'h30, 32'h0, 3'd4, 1'b1);
        collect("reset_mid_store_kept", 1'b1);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t e2;
        start_req(1'b0, 32'h10, 32'h0, 3'd4, 1'b0);
        model_apply(1'b0, 32'h10, 32'h0, 3'd4, e);
        repeat (LATENCY) begin
            @(posedge clk_i);
            #1;
        end
        n_tests++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%b rdata=%h err=%b required 1/%h/%b",
                     rsp_valid_o, rsp_rdata_o, rsp_err_o, e.rdata, e.err);
        end
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 32'h20;
        req_len_i   = 3'd4;
        model_apply(1'b0, 32'h20, 32'h0, 3'd4, e2);
        exp_q.push_back(e2);
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
        n_tests++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_no_same_edge: rsp_valid_o=%b req_ready_o=%b required 0/1",
                     rsp_valid_o, req_ready_o);
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        n_tests++;
        if (req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept_next: req_ready_o=%b required 0", req_ready_o);
        end
        collect("b2b_second", 1'b1);
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_merge();
        test_errors();
        test_bounds();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
